freq_sweep_ctrl: RTL

Programmable frequency-sweep sequencer that drives the `freq` input of the CORDIC sine generator (angle generator + CORDIC pipeline).
- Steps `freq` from a start value to a stop value in fixed increments.
- Holds each frequency for a programmable dwell time.
- Runs single-shot or continuous (auto-restart).
- Provides start/abort control and busy/done/wrap status, so higher-level logic can run chirps and frequency-response measurements.

---
 rtl/freq_sweep_pkg.sv | 14 +
 rtl/freq_sweep_ctrl_if.sv | 33 +++
 rtl/sweep_step_calc.sv | 31 +++
 rtl/freq_sweep_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/freq_sweep_pkg.sv
// Shared widths and state encoding for the frequency-sweep sequencer.
package freq_sweep_pkg;

  localparam int unsigned FREQ_WIDTH  = 16;
  localparam int unsigned DWELL_WIDTH = 16;
  localparam int unsigned IDX_WIDTH   = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/freq_sweep_ctrl_if.sv
// Control/status bundle between sweep master logic and the sweep sequencer.
interface freq_sweep_ctrl_if
  import freq_sweep_pkg::*;
#(
  parameter int unsigned FW = FREQ_WIDTH,
  parameter int unsigned DW = DWELL_WIDTH,
  parameter int unsigned IW = IDX_WIDTH
);

  logic          start;
  logic          abort;
  logic          cont;
  logic [FW-1:0] f_start;
  logic [FW-1:0] f_stop;
  logic [FW-1:0] f_step;
  logic [DW-1:0] dwell;
  logic [FW-1:0] freq;
  logic          busy;
  logic          done;
  logic          wrap;
  logic [IW-1:0] step_idx;

  modport master (
    output start, abort, cont, f_start, f_stop, f_step, dwell,
    input  freq, busy, done, wrap, step_idx
  );

  modport slave (
    input  start, abort, cont, f_start, f_stop, f_step, dwell,
    output freq, busy, done, wrap, step_idx
  );

endinterface

// File: rtl/sweep_step_calc.sv
// Next sweep point: one step toward f_stop, clamped at f_stop, never wrapping.
module sweep_step_calc #(
  parameter int unsigned FREQ_WIDTH = 16
) (
  input  logic [FREQ_WIDTH-1:0] freq,
  input  logic [FREQ_WIDTH-1:0] f_stop,
  input  logic [FREQ_WIDTH-1:0] f_step,
  input  logic                  down,
  output logic [FREQ_WIDTH-1:0] next_freq_c,
  output logic                  is_last_c
);

  logic [FREQ_WIDTH:0] sum;
  logic [FREQ_WIDTH:0] diff;

  // Extra MSB carries the overflow (up) or borrow (down) so clamping is exact.
  always_comb begin
    sum         = {1'b0, freq} + {1'b0, f_step};
    diff        = {1'b0, freq} - {1'b0, f_step};
    next_freq_c = freq;
    if (down) begin
      if (diff[FREQ_WIDTH] || (diff[FREQ_WIDTH-1:0] < f_stop)) next_freq_c = f_stop;
      else                                                      next_freq_c = diff[FREQ_WIDTH-1:0];
    end else begin
      if (sum > {1'b0, f_stop}) next_freq_c = f_stop;
      else                      next_freq_c = sum[FREQ_WIDTH-1:0];
    end
    is_last_c = (freq == f_stop);
  end

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the CORDIC sine generator's freq input.
module freq_sweep_ctrl
  import freq_sweep_pkg::*;
#(
  parameter int unsigned FREQ_WIDTH  = freq_sweep_pkg::FREQ_WIDTH,
  parameter int unsigned DWELL_WIDTH = freq_sweep_pkg::DWELL_WIDTH,
  parameter int unsigned IDX_WIDTH   = freq_sweep_pkg::IDX_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  freq_sweep_ctrl_if.slave   sw
);

  state_t                 state_q, state_d;
  logic [FREQ_WIDTH-1:0]  freq_q, freq_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   wrap_q, wrap_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic [FREQ_WIDTH-1:0]  cfg_start_q, cfg_start_d;
  logic [FREQ_WIDTH-1:0]  cfg_stop_q, cfg_stop_d;
  logic [FREQ_WIDTH-1:0]  cfg_step_q, cfg_step_d;
  logic [DWELL_WIDTH-1:0] cfg_dwell_q, cfg_dwell_d;
  logic                   cfg_cont_q, cfg_cont_d;
  logic                   cfg_down_q, cfg_down_d;
  logic [FREQ_WIDTH-1:0]  next_freq_c;
  logic                   is_last_c;

  sweep_step_calc #(.FREQ_WIDTH(FREQ_WIDTH)) u_step (
    .freq        (freq_q),
    .f_stop      (cfg_stop_q),
    .f_step      (cfg_step_q),
    .down        (cfg_down_q),
    .next_freq_c (next_freq_c),
    .is_last_c   (is_last_c)
  );

  // State, outputs and latched sweep configuration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      freq_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      cfg_start_q <= '0;
      cfg_stop_q  <= '0;
      cfg_step_q  <= '0;
      cfg_dwell_q <= '0;
      cfg_cont_q  <= 1'b0;
      cfg_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      cfg_start_q <= cfg_start_d;
      cfg_stop_q  <= cfg_stop_d;
      cfg_step_q  <= cfg_step_d;
      cfg_dwell_q <= cfg_dwell_d;
      cfg_cont_q  <= cfg_cont_d;
      cfg_down_q  <= cfg_down_d;
    end
  end

  // Next-state and next-output logic; abort overrides every state.
  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wrap_d      = 1'b0;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    cfg_start_d = cfg_start_q;
    cfg_stop_d  = cfg_stop_q;
    cfg_step_d  = cfg_step_q;
    cfg_dwell_d = cfg_dwell_q;
    cfg_cont_d  = cfg_cont_q;
    cfg_down_d  = cfg_down_q;

    case (state_q)
      IDLE: begin
        if (sw.abort) begin
          freq_d = '0;
          busy_d = 1'b0;
        end else if (sw.start) begin
          state_d     = DWELL;
          freq_d      = sw.f_start;
          busy_d      = 1'b1;
          idx_d       = '0;
          cnt_d       = sw.dwell;
          cfg_start_d = sw.f_start;
          cfg_stop_d  = sw.f_stop;
          // A zero step would never reach a distinct stop value.
          cfg_step_d  = ((sw.f_step == '0) && (sw.f_start != sw.f_stop))
                        ? FREQ_WIDTH'(1) : sw.f_step;
          cfg_dwell_d = sw.dwell;
          cfg_cont_d  = sw.cont;
          cfg_down_d  = (sw.f_stop < sw.f_start);
        end
      end
      DWELL: begin
        if (sw.abort) begin
          state_d = IDLE;
          freq_d  = '0;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_WIDTH'(1);
        end else if (!is_last_c) begin
          freq_d = next_freq_c;
          idx_d  = idx_q + IDX_WIDTH'(1);
          cnt_d  = cfg_dwell_q;
        end else if (cfg_cont_q) begin
          freq_d = cfg_start_q;
          idx_d  = '0;
          wrap_d = 1'b1;
          cnt_d  = cfg_dwell_q;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (sw.abort) freq_d = '0;
      end
      default: begin
        state_d = IDLE;
        freq_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign sw.freq     = freq_q;
  assign sw.busy     = busy_q;
  assign sw.done     = done_q;
  assign sw.wrap     = wrap_q;
  assign sw.step_idx = idx_q;

endmodule
